// File: rtl/any1_pkg.sv
// any1 memory sequencer shared types.
// Bus geometry, sequencer states and the unaligned select type.
package any1_pkg;

    localparam int BUS_BYTES = 16;

    typedef logic [31:0] usel_t;

    typedef enum logic [2:0] {
        IDLE,
        BUS1,
        WAIT1,
        BUS2,
        DONE
    } seq_state_t;

endpackage

// File: rtl/any1_mem_sequencer_if.sv
// 128-bit classic-handshake data bus between sequencer and cache/bus.
// master = sequencer side, slave = memory side.
interface any1_mem_sequencer_if;

    logic         cyc_o;
    logic         stb_o;
    logic         we_o;
    logic [15:0]  sel_o;
    logic [31:0]  adr_o;
    logic [127:0] dat_o;
    logic         ack_i;
    logic         err_i;
    logic [127:0] dat_i;

    modport master (
        output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        input  ack_i, err_i, dat_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        output ack_i, err_i, dat_i
    );

endinterface

// File: rtl/any1_mem_align.sv
// Lane alignment: shifts select/store data out to the bus and
// merges/right-aligns the two returned bus words for loads.
module any1_mem_align
    import any1_pkg::*;
(
    input  logic [3:0]   sh,
    input  usel_t        sel,
    input  logic [127:0] stdat,
    output usel_t        s32,
    output logic [255:0] d256,
    input  logic [3:0]   ldsh,
    input  logic [127:0] lo,
    input  logic [127:0] hi,
    output logic [127:0] lddat
);

    assign s32   = sel << sh;
    assign d256  = {128'b0, stdat} << {sh, 3'b000};
    assign lddat = 128'({hi, lo} >> {ldsh, 3'b000});

endmodule

// File: rtl/any1_mem_sequencer.sv
// Load/store sequencer onto the 128-bit classic-handshake bus.
// Optional ack timeout: define ANY1_SEQ_TIMEOUT_EN.
module any1_mem_sequencer
    import any1_pkg::*;
#(
    parameter int TMO_CYCLES = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    input  logic         we_i,
    input  logic [31:0]  adr_i,
    input  usel_t        sel_i,
    input  logic [127:0] stdat_i,
    output logic         rdy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [127:0] lddat_o,
    any1_mem_sequencer_if.master bus
);

    if (TMO_CYCLES < 1 || TMO_CYCLES > 256) begin : g_bad_tmo
        $error("TMO_CYCLES must be in 1..256");
    end

    seq_state_t   state_q, state_d;
    logic         cyc_q, cyc_d;
    logic         stb_q, stb_d;
    logic         we_q, we_d;
    logic [15:0]  sel_q, sel_d;
    logic [31:0]  adr_q, adr_d;
    logic [127:0] dat_q, dat_d;
    logic [127:0] lo_q, lo_d;
    logic [127:0] hi_q, hi_d;
    logic [127:0] ld_q, ld_d;
    logic [3:0]   sh_q, sh_d;
    logic         two_q, two_d;
    logic [15:0]  selhi_q, selhi_d;
    logic [127:0] dhi_q, dhi_d;
    logic         wr_q, wr_d;
    logic         errs_q, errs_d;

    usel_t        s32;
    logic [255:0] d256;
    logic [127:0] merged;
    logic         ack;
    logic         tmo;
    logic         berr;
    logic         fin;

    any1_mem_align u_align (
        .sh    (adr_i[3:0]),
        .sel   (sel_i),
        .stdat (stdat_i),
        .s32   (s32),
        .d256  (d256),
        .ldsh  (sh_q),
        .lo    (lo_d),
        .hi    (hi_d),
        .lddat (merged)
    );

    // Simultaneous ack and err counts as an error.
    assign ack  = bus.ack_i | bus.err_i;
    assign berr = bus.err_i | tmo;
    assign fin  = ack | tmo;

`ifdef ANY1_SEQ_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       inbus;

    assign inbus = (state_q == BUS1) || (state_q == BUS2);
    assign tmo   = inbus && !ack && (cnt_q == 8'(TMO_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == BUS1 || state_d == BUS2) && state_d != state_q)
            cnt_d = '0;
        else if (inbus && !ack)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        sh_d    = sh_q;
        two_d   = two_q;
        selhi_d = selhi_q;
        dhi_d   = dhi_q;
        wr_d    = wr_q;
        errs_d  = errs_q;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    sh_d    = adr_i[3:0];
                    two_d   = |s32[31:16];
                    selhi_d = s32[31:16];
                    dhi_d   = d256[255:128];
                    wr_d    = we_i;
                    errs_d  = 1'b0;
                    lo_d    = '0;
                    hi_d    = '0;
                    if (s32 == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUS1;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = we_i;
                        sel_d   = s32[15:0];
                        adr_d   = {adr_i[31:4], 4'h0};
                        dat_d   = d256[127:0];
                    end
                end
            end
            BUS1: begin
                if (fin) begin
                    if (ack) lo_d = bus.dat_i;
                    stb_d  = 1'b0;
                    errs_d = berr;
                    if (berr || !two_q) begin
                        cyc_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT1;
                    end
                end
            end
            WAIT1: begin
                if (!bus.ack_i) begin
                    state_d = BUS2;
                    stb_d   = 1'b1;
                    sel_d   = selhi_q;
                    adr_d   = adr_q + 32'(BUS_BYTES);
                    dat_d   = dhi_q;
                end
            end
            BUS2: begin
                if (fin) begin
                    if (ack) hi_d = bus.dat_i;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    errs_d  = errs_q | berr;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load data is latched on the way into DONE so it is valid with done_o.
    always_comb begin
        ld_d = ld_q;
        if (state_d == DONE && !wr_q &&
            (state_q == BUS1 || state_q == BUS2))
            ld_d = merged;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            ld_q    <= '0;
            sh_q    <= '0;
            two_q   <= 1'b0;
            selhi_q <= '0;
            dhi_q   <= '0;
            wr_q    <= 1'b0;
            errs_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ld_q    <= ld_d;
            sh_q    <= sh_d;
            two_q   <= two_d;
            selhi_q <= selhi_d;
            dhi_q   <= dhi_d;
            wr_q    <= wr_d;
            errs_q  <= errs_d;
        end
    end

    assign rdy_o     = (state_q == IDLE);
    assign done_o    = (state_q == DONE);
    assign err_o     = (state_q == DONE) && errs_q;
    assign lddat_o   = ld_q;
    assign bus.cyc_o = cyc_q;
    assign bus.stb_o = stb_q;
    assign bus.we_o  = we_q;
    assign bus.sel_o = sel_q;
    assign bus.adr_o = adr_q;
    assign bus.dat_o = dat_q;

endmodule

// File: tb/tb_any1_mem_sequencer.sv
// Directed bench for any1_mem_sequencer: vector table plus
// hand sequences for error, no-op, reset and timeout paths.
module tb_any1_mem_sequencer;

    logic         clk;
    logic         rst_i;
    logic         req_i;
    logic         we_i;
    logic [31:0]  adr_i;
    logic [31:0]  sel_i;
    logic [127:0] stdat_i;
    logic         rdy_o;
    logic         done_o;
    logic         err_o;
    logic [127:0] lddat_o;

    any1_mem_sequencer_if bus();

    any1_mem_sequencer #(.TMO_CYCLES(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .adr_i   (adr_i),
        .sel_i   (sel_i),
        .stdat_i (stdat_i),
        .rdy_o   (rdy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .lddat_o (lddat_o),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [31:0]  adr;
        logic [31:0]  sel;
        logic [127:0] st;
        logic [127:0] lo;
        logic [127:0] hi;
        int           wt;
        logic         two;
        logic [31:0]  a1;
        logic [31:0]  a2;
        logic [15:0]  s1;
        logic [15:0]  s2;
        logic [127:0] d1;
        logic [127:0] d2;
        logic [127:0] ld;
    } vec_t;

    vec_t         tv [6];
    int           checks;
    int           failures;
    int           cur;
    logic [127:0] last_ld;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (case %0d) actual=%h required=%h",
                     nm, cur, act, exp);
        end
    endtask

    task automatic start(input vec_t v);
        req_i   = 1'b1;
        we_i    = v.we;
        adr_i   = v.adr;
        sel_i   = v.sel;
        stdat_i = v.st;
        @(negedge clk);
        req_i   = 1'b0;
    endtask

    task automatic do_access(input vec_t v);
        logic [127:0] exp;
        chk("rdy", rdy_o, 1);
        start(v);
        chk("b1_cyc", bus.cyc_o, 1);
        chk("b1_stb", bus.stb_o, 1);
        chk("b1_we", bus.we_o, v.we);
        chk("b1_adr", bus.adr_o, v.a1);
        chk("b1_sel", bus.sel_o, v.s1);
        chk("b1_dat", bus.dat_o, v.d1);
        chk("b1_rdy", rdy_o, 0);
        repeat (v.wt) @(negedge clk);
        bus.ack_i = 1'b1;
        bus.dat_i = v.lo;
        @(negedge clk);
        bus.ack_i = 1'b0;
        if (v.two) begin
            chk("w1_stb", bus.stb_o, 0);
            chk("w1_cyc", bus.cyc_o, 1);
            @(negedge clk);
            chk("b2_stb", bus.stb_o, 1);
            chk("b2_adr", bus.adr_o, v.a2);
            chk("b2_sel", bus.sel_o, v.s2);
            chk("b2_dat", bus.dat_o, v.d2);
            bus.ack_i = 1'b1;
            bus.dat_i = v.hi;
            @(negedge clk);
            bus.ack_i = 1'b0;
        end
        exp = v.we ? last_ld : v.ld;
        chk("done", done_o, 1);
        chk("done_err", err_o, 0);
        chk("done_cyc", bus.cyc_o, 0);
        chk("done_stb", bus.stb_o, 0);
        chk("lddat", lddat_o, exp);
        if (!v.we) last_ld = v.ld;
        @(negedge clk);
        chk("idle_done", done_o, 0);
        chk("idle_rdy", rdy_o, 1);
        chk("lddat_hold", lddat_o, exp);
    endtask

    initial begin
        vec_t v;
        int   n;
        checks    = 0;
        failures  = 0;
        cur       = -1;
        last_ld   = '0;
        rst_i     = 1'b1;
        req_i     = 1'b0;
        we_i      = 1'b0;
        adr_i     = '0;
        sel_i     = '0;
        stdat_i   = '0;
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        bus.dat_i = '0;

        tv[0] = '{1'b0, 32'h1000, 32'hFFFF, '0,
                  128'h0F0E0D0C0B0A09080706050403020100, '0, 2, 1'b0,
                  32'h1000, 32'h1010, 16'hFFFF, 16'h0000, '0, '0,
                  128'h0F0E0D0C0B0A09080706050403020100};
        tv[1] = '{1'b1, 32'h100C, 32'h00FF, 128'h8877665544332211,
                  '0, '0, 0, 1'b1,
                  32'h1000, 32'h1010, 16'hF000, 16'h000F,
                  {32'h44332211, 96'h0}, 128'h88776655, '0};
        tv[2] = '{1'b0, 32'h201F, 32'h0003, '0,
                  {8'hAB, 120'h0}, 128'hCD, 1, 1'b1,
                  32'h2010, 32'h2020, 16'h8000, 16'h0001, '0, '0,
                  128'hCDAB};
        tv[3] = '{1'b0, 32'h201E, 32'h0003, '0,
                  {16'hABCD, 112'h0}, '0, 0, 1'b0,
                  32'h2010, 32'h2020, 16'hC000, 16'h0000, '0, '0,
                  128'hABCD};
        tv[4] = '{1'b1, 32'h3004, 32'h000F, 128'hDEADBEEF,
                  '0, '0, 0, 1'b0,
                  32'h3000, 32'h3010, 16'h00F0, 16'h0000,
                  128'hDEADBEEF_00000000, '0, '0};
        tv[5] = '{1'b0, 32'hFFFF_FFF8, 32'hFFFF, '0,
                  128'h11111111111111112222222222222222,
                  128'h33333333333333334444444444444444, 0, 1'b1,
                  32'hFFFF_FFF0, 32'h0000_0000, 16'hFF00, 16'h00FF,
                  '0, '0,
                  128'h44444444444444441111111111111111};

        repeat (2) @(negedge clk);
        chk("rst_rdy", rdy_o, 1);
        chk("rst_cyc", bus.cyc_o, 0);
        chk("rst_stb", bus.stb_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_sel", bus.sel_o, 0);
        chk("rst_adr", bus.adr_o, 0);
        chk("rst_lddat", lddat_o, 0);
        rst_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            cur = i;
            do_access(tv[i]);
        end

        cur = 10;
        v = tv[0];
        v.sel = '0;
        start(v);
        chk("nop_cyc", bus.cyc_o, 0);
        chk("nop_done", done_o, 1);
        chk("nop_err", err_o, 0);
        @(negedge clk);
        chk("nop_rdy", rdy_o, 1);

        cur = 11;
        start(tv[2]);
        chk("e1_cyc", bus.cyc_o, 1);
        bus.err_i = 1'b1;
        @(negedge clk);
        bus.err_i = 1'b0;
        chk("e1_done", done_o, 1);
        chk("e1_err", err_o, 1);
        chk("e1_cyc_drop", bus.cyc_o, 0);
        chk("e1_stb_drop", bus.stb_o, 0);
        @(negedge clk);
        chk("e1_idle_done", done_o, 0);
        chk("e1_idle_err", err_o, 0);
        chk("e1_rdy", rdy_o, 1);

        cur = 12;
        start(tv[1]);
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        @(negedge clk);
        chk("e2_b2_stb", bus.stb_o, 1);
        bus.ack_i = 1'b1;
        bus.err_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        chk("e2_done", done_o, 1);
        chk("e2_err", err_o, 1);
        chk("e2_cyc", bus.cyc_o, 0);
        @(negedge clk);

        cur = 13;
        start(tv[1]);
        bus.ack_i = 1'b1;
        @(negedge clk);
        bus.ack_i = 1'b0;
        @(negedge clk);
        chk("r_b2_cyc", bus.cyc_o, 1);
        chk("r_b2_stb", bus.stb_o, 1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("r_cyc", bus.cyc_o, 0);
        chk("r_stb", bus.stb_o, 0);
        chk("r_rdy", rdy_o, 1);
        chk("r_done", done_o, 0);
        chk("r_lddat", lddat_o, 0);
        last_ld = '0;
        do_access(tv[2]);

        cur = 14;
        start(tv[0]);
        chk("t_cyc", bus.cyc_o, 1);
`ifdef ANY1_SEQ_TIMEOUT_EN
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            if (n == 0) begin
                @(negedge clk);
                if (!bus.cyc_o) n = k;
            end
        end
        chk("t_drop", (n >= 1 && n <= 5), 1);
        chk("t_done", done_o, 1);
        chk("t_err", err_o, 1);
        @(negedge clk);
        chk("t_rdy", rdy_o, 1);
`else
        n = 12;
        repeat (n) @(negedge clk);
        chk("t_hold_cyc", bus.cyc_o, 1);
        chk("t_hold_done", done_o, 0);
        bus.ack_i = 1'b1;
        bus.dat_i = tv[0].lo;
        @(negedge clk);
        bus.ack_i = 1'b0;
        chk("t_done", done_o, 1);
        chk("t_err", err_o, 0);
        chk("t_lddat", lddat_o, tv[0].ld);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
